// File: rtl/pipe_pkg.sv
// Shared definitions for the 3-stage pipeline sequencing controller:
// FSM state encoding, trap causes and instruction register-field positions.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_BUSERR = 2'd1;
  localparam logic [1:0] CAUSE_IRQ    = 2'd2;

  // Register-index fields: rd in MW, rs1/rs2 in EM
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned RD_LSB    = 7;
  localparam int unsigned RS1_LSB   = 15;
  localparam int unsigned RS2_LSB   = 20;

endpackage

// File: rtl/fwd_compare.sv
// MW -> EM operand forwarding match for one source operand.
// x0 is never forwarded; the MW result must be valid and actually written back.
module fwd_compare
  import pipe_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rd,
  input  logic [REG_IDX_W-1:0] rs,
  input  logic                 reg_wr,
  input  logic                 valid,
  output logic                 fwd
);

  assign fwd = reg_wr & valid & (rd != {REG_IDX_W{1'b0}}) & (rd == rs);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/bubble sequencing, data-memory wait/timeout and trap entry for the
// FD/EM/MW pipeline. Define PIPE_CTRL_IRQ_EN to enable the interrupt trap path.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int Width      = 32,
  parameter int MemTimeout = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] ir_EM,
  input  logic [Width-1:0] ir_MW,
  input  logic             reg_wrMW,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             br_taken,
  input  logic             irq,
  output logic             stall,
  output logic             stall_MW,
  output logic             flush,
  output logic             flush_EM,
  output logic             fora,
  output logic             forb,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  localparam int CntW = $clog2(MemTimeout + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MemTimeout);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntZero = {CntW{1'b0}};

  state_e          state_r, state_nxt_s;
  logic [CntW-1:0] wait_cnt_r, wait_cnt_nxt_s;
  logic [1:0]      cause_r, cause_nxt_s;
  logic            valid_mw_r;
  logic            valid_fwd_s;
  logic            unused_s;

  // Only the register-index fields of the instruction words are consumed here
  assign unused_s = ^{irq, ir_EM, ir_MW};

  // Next-state and same-cycle stall/flush/trap outputs
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    cause_nxt_s    = cause_r;
    stall          = 1'b0;
    stall_MW       = 1'b0;
    flush          = 1'b0;
    flush_EM       = 1'b0;
    trap           = 1'b0;
    trap_cause     = CAUSE_NONE;
    if (rst) begin
      flush    = 1'b1;
      flush_EM = 1'b1;
      stall_MW = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_req && !mem_ack) begin
            stall          = 1'b1;
            stall_MW       = 1'b1;
            state_nxt_s    = MEM_WAIT;
            wait_cnt_nxt_s = CntOne;
          end else begin
            flush = br_taken;
`ifdef PIPE_CTRL_IRQ_EN
            if (irq && !mem_req) begin
              state_nxt_s = TRAP;
              cause_nxt_s = CAUSE_IRQ;
            end else begin
              state_nxt_s = RUN;
            end
`endif
          end
        end
        MEM_WAIT: begin
          // An ack in the timeout cycle wins over the bus-error trap
          if (mem_ack) begin
            flush          = br_taken;
            state_nxt_s    = RUN;
            wait_cnt_nxt_s = CntZero;
          end else begin
            stall    = 1'b1;
            stall_MW = 1'b1;
            if (wait_cnt_r == CntMax) begin
              state_nxt_s = TRAP;
              cause_nxt_s = CAUSE_BUSERR;
            end else begin
              wait_cnt_nxt_s = wait_cnt_r + CntOne;
            end
          end
        end
        TRAP: begin
          trap           = 1'b1;
          trap_cause     = cause_r;
          flush          = 1'b1;
          flush_EM       = 1'b1;
          stall_MW       = 1'b1;
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = CntZero;
        end
        default: begin
          flush          = 1'b1;
          flush_EM       = 1'b1;
          stall_MW       = 1'b1;
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = CntZero;
        end
      endcase
    end
  end

  // State, wait counter, trap cause and MW-valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= CntZero;
      cause_r    <= CAUSE_NONE;
      valid_mw_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      cause_r    <= cause_nxt_s;
      valid_mw_r <= ~(stall_MW | flush_EM);
    end
  end

  assign valid_fwd_s = valid_mw_r & ~rst;

  fwd_compare u_fwd_a (
    .rd     (ir_MW[RD_LSB +: REG_IDX_W]),
    .rs     (ir_EM[RS1_LSB +: REG_IDX_W]),
    .reg_wr (reg_wrMW),
    .valid  (valid_fwd_s),
    .fwd    (fora)
  );

  fwd_compare u_fwd_b (
    .rd     (ir_MW[RD_LSB +: REG_IDX_W]),
    .rs     (ir_EM[RS2_LSB +: REG_IDX_W]),
    .reg_wr (reg_wrMW),
    .valid  (valid_fwd_s),
    .fwd    (forb)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-level reference model pushes the
// expected outputs of every cycle; a negedge monitor pops and compares them.
module tb_pipe_ctrl;

  localparam int T = 4;
`ifdef PIPE_CTRL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ir_EM = 32'd0;
  logic [31:0] ir_MW = 32'd0;
  logic        reg_wrMW = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
  logic        br_taken = 1'b0, irq = 1'b0;
  logic        stall, stall_MW, flush, flush_EM, fora, forb, trap;
  logic [1:0]  trap_cause;

  typedef struct {
    logic       stall, stall_MW, flush, flush_EM, fora, forb, trap;
    logic [1:0] cause;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  // Reference model: what the pipeline is doing, not how the RTL encodes it
  bit m_waiting = 1'b0;
  int m_miss_cyc = 0;
  int m_trap = 0;
  bit m_mw_valid = 1'b0;
  int cyc = 0;

  pipe_ctrl #(.Width(32), .MemTimeout(T)) dut (
    .clk(clk), .rst(rst), .ir_EM(ir_EM), .ir_MW(ir_MW), .reg_wrMW(reg_wrMW),
    .mem_req(mem_req), .mem_ack(mem_ack), .br_taken(br_taken), .irq(irq),
    .stall(stall), .stall_MW(stall_MW), .flush(flush), .flush_EM(flush_EM),
    .fora(fora), .forb(forb), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle, compared mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty @cyc %0d: got 0 entries expected 1", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("stall",      {1'b0, stall},    {1'b0, e.stall});
        chk("stall_MW",   {1'b0, stall_MW}, {1'b0, e.stall_MW});
        chk("flush",      {1'b0, flush},    {1'b0, e.flush});
        chk("flush_EM",   {1'b0, flush_EM}, {1'b0, e.flush_EM});
        chk("fora",       {1'b0, fora},     {1'b0, e.fora});
        chk("forb",       {1'b0, forb},     {1'b0, e.forb});
        chk("trap",       {1'b0, trap},     {1'b0, e.trap});
        chk("trap_cause", trap_cause,       e.cause);
      end
    end
  end

  task automatic step(input logic r, input logic req, input logic ack, input logic br,
                      input logic ir, input logic wr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2);
    exp_t        e;
    logic [31:0] w;
    bit          n_waiting, n_mw_valid;
    int          n_miss, n_trap;
    rst = r; mem_req = req; mem_ack = ack; br_taken = br; irq = ir; reg_wrMW = wr;
    w = $urandom; w[19:15] = rs1; w[24:20] = rs2; ir_EM = w;
    w = $urandom; w[11:7] = rd; ir_MW = w;

    e = '{stall: 1'b0, stall_MW: 1'b0, flush: 1'b0, flush_EM: 1'b0,
          fora: 1'b0, forb: 1'b0, trap: 1'b0, cause: 2'd0};
    n_waiting = m_waiting; n_miss = m_miss_cyc; n_trap = 0; n_mw_valid = 1'b0;
    if (r) begin
      e.flush = 1'b1; e.flush_EM = 1'b1; e.stall_MW = 1'b1;
      n_waiting = 1'b0;
    end else if (m_trap != 0) begin
      e.trap = 1'b1; e.cause = 2'(m_trap);
      e.flush = 1'b1; e.flush_EM = 1'b1; e.stall_MW = 1'b1;
      n_waiting = 1'b0;
    end else if (m_waiting) begin
      if (ack) begin
        e.flush = br; n_waiting = 1'b0; n_mw_valid = 1'b1;
      end else begin
        e.stall = 1'b1; e.stall_MW = 1'b1;
        if (cyc - m_miss_cyc == T) begin
          n_trap = 1; n_waiting = 1'b0;
        end
      end
    end else begin
      if (req && !ack) begin
        e.stall = 1'b1; e.stall_MW = 1'b1; n_waiting = 1'b1; n_miss = cyc;
      end else begin
        e.flush = br; n_mw_valid = 1'b1;
        if (IRQ_EN && ir && !req) n_trap = 2;
      end
    end
    e.fora = !r && wr && m_mw_valid && (rd != 5'd0) && (rd == rs1);
    e.forb = !r && wr && m_mw_valid && (rd != 5'd0) && (rd == rs2);
    q.push_back(e);
    mon_en = 1'b1;

    @(posedge clk);
    m_waiting = n_waiting; m_miss_cyc = n_miss; m_trap = n_trap; m_mw_valid = n_mw_valid;
    cyc++;
    #1;
  endtask

  // Run-cycle shorthand: no memory, branch or interrupt activity
  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    @(posedge clk); #1;
    // Reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5);
    idle();
    // Forwarding: rd 5 matches rs1 only, then x0 never forwards
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd2, 5'd9);
    // Memory ack three cycles after the miss, then forwarding shows MW is valid
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd7);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd7);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd1);
    // Branch in RUN, then branch held across a two-cycle memory wait
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle();
    // Timeout: no ack ever, trap after T+1 stalled cycles
    for (int i = 0; i < T + 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd4);
    idle();
    // Ack in the timeout cycle resolves as ack
    for (int i = 0; i < T; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle();
    idle();
    // Interrupt in RUN, and interrupt held during a memory wait
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    idle();
    // Reset mid-wait with a late ack, then a clean RUN cycle
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd3);
    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end
    mon_en = 1'b0;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
